// File: rtl/serial_tx_sched_if.sv
// serial_tx_sched_if: bundle between two parallel requesters, the scheduler and the serial line.
// Latency: none, wires only.
// Backpressure: requesters hold req/data until their gnt pulse; the serial side cannot stall.
// Ports:
//   req0/data0, req1/data1 : requests and WIDTH-bit words (driven by the requester side)
//   gnt0/gnt1, done        : one-cycle pulses from the scheduler
//   so/so_valid/owner      : serial bit, its qualifier and the index of the port being shifted
interface serial_tx_sched_if #(
    parameter int WIDTH = 4
);
    logic             req0;
    logic [WIDTH-1:0] data0;
    logic             req1;
    logic [WIDTH-1:0] data1;
    logic             gnt0;
    logic             gnt1;
    logic             so;
    logic             so_valid;
    logic             owner;
    logic             done;

    // Requester and serial-consumer side.
    modport master (
        output req0, data0, req1, data1,
        input  gnt0, gnt1, so, so_valid, owner, done
    );

    // Scheduler side.
    modport slave (
        input  req0, data0, req1, data1,
        output gnt0, gnt1, so, so_valid, owner, done
    );
endinterface

// File: rtl/serial_tx_sched.sv
// serial_tx_sched: round-robin arbiter for two requesters feeding one LSB-first serial line.
// Latency: first bit on so one cycle after the sampling edge; WIDTH bits back-to-back, no gap between words.
// Backpressure: none on the serial side; requesters wait for gnt, sampled only in IDLE or on a word's last bit.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-low reset, abandons any word in flight without a done pulse
//   bus : serial_tx_sched_if.slave (req/data in, gnt/so/so_valid/owner/done out)
module serial_tx_sched #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    serial_tx_sched_if.slave   bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] q_q;
    logic [CW-1:0]    cnt_q;
    logic             ptr_q;
    logic             owner_q;
    logic             gnt0_q;
    logic             gnt1_q;
    logic             done_q;

    logic             last_bit;
    logic             sample;
    logic             any_req;
    logic             win;
    logic [WIDTH-1:0] win_data;

    // The edge ending the last bit doubles as a sample point so words run back-to-back.
    assign last_bit = (state_q == SHIFT) && (cnt_q == '0);
    assign sample   = (state_q == IDLE) || last_bit;
    assign any_req  = bus.req0 | bus.req1;
    // Port 1 wins when alone, or when both ask and the pointer favours it.
    assign win      = bus.req1 & (~bus.req0 | ptr_q);
    assign win_data = win ? bus.data1 : bus.data0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            q_q     <= '0;
            cnt_q   <= '0;
            ptr_q   <= 1'b0;
            owner_q <= 1'b0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            gnt0_q <= 1'b0;
            gnt1_q <= 1'b0;
            done_q <= last_bit;
            if (sample && any_req) begin
                q_q     <= win_data;
                cnt_q   <= LAST;
                state_q <= SHIFT;
                owner_q <= win;
                ptr_q   <= ~win;
                gnt0_q  <= ~win;
                gnt1_q  <= win;
            end else if (state_q == SHIFT) begin
                if (last_bit) begin
                    // Clear q so the idle line reads 0.
                    q_q     <= '0;
                    state_q <= IDLE;
                end else begin
                    q_q   <= {1'b0, q_q[WIDTH-1:1]};
                    cnt_q <= cnt_q - 1'b1;
                end
            end
        end
    end

    assign bus.so       = q_q[0];
    assign bus.so_valid = (state_q == SHIFT);
    assign bus.owner    = owner_q;
    assign bus.gnt0     = gnt0_q;
    assign bus.gnt1     = gnt1_q;
    assign bus.done     = done_q;
endmodule

// File: tb/tb_serial_tx_sched.sv
// tb_serial_tx_sched: directed scenarios plus randomized traffic against a word-level reference model.
// Latency: n/a (bench).
// Backpressure: requesters drop req in the gnt cycle the model predicts.
module tb_serial_tx_sched;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    serial_tx_sched_if #(.WIDTH(W)) bus ();
    serial_tx_sched #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: the word on the line, which of its bits is being sent, and the fairness pointer.
    bit           m_busy;
    bit           m_owner;
    bit           m_ptr;
    bit           m_g0;
    bit           m_g1;
    bit           m_dn;
    int           m_bit;
    logic [W-1:0] m_word;

    function automatic void model_reset();
        m_busy  = 0;
        m_owner = 0;
        m_ptr   = 0;
        m_g0    = 0;
        m_g1    = 0;
        m_dn    = 0;
        m_bit   = 0;
        m_word  = '0;
    endfunction

    function automatic void model_edge(bit r0, bit r1, logic [W-1:0] d0, logic [W-1:0] d1);
        bit win;
        bit finishing;
        finishing = m_busy && (m_bit == W - 1);
        m_g0 = 0;
        m_g1 = 0;
        m_dn = finishing;
        if (!m_busy || finishing) begin
            if (r0 || r1) begin
                win     = (r0 && r1) ? m_ptr : r1;
                m_ptr   = !win;
                m_owner = win;
                m_word  = win ? d1 : d0;
                m_bit   = 0;
                m_busy  = 1;
                if (win) m_g1 = 1;
                else     m_g0 = 1;
            end else begin
                m_busy = 0;
            end
        end else begin
            m_bit++;
        end
    endfunction

    function automatic logic [5:0] exp_vec();
        logic s;
        s = m_busy ? m_word[m_bit] : 1'b0;
        return {m_g0, m_g1, m_dn, s, m_busy, m_owner & m_busy};
    endfunction

    function automatic logic [5:0] obs_vec();
        return {bus.gnt0, bus.gnt1, bus.done, bus.so, bus.so_valid, bus.owner & bus.so_valid};
    endfunction

    task automatic tick();
        @(posedge clk);
        if (!rst) model_reset();
        else      model_edge(bus.req0, bus.req1, bus.data0, bus.data1);
        #1;
    endtask

    task automatic clear_reqs();
        bus.req0  = 1'b0;
        bus.req1  = 1'b0;
        bus.data0 = '0;
        bus.data1 = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        clear_reqs();
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        clear_reqs();
        model_reset();
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if ({bus.gnt0, bus.gnt1, bus.done, bus.so, bus.so_valid, bus.owner} !== 6'b0) begin
                n_err++;
                $display("FAIL reset_outputs: got %b expected 000000",
                         {bus.gnt0, bus.gnt1, bus.done, bus.so, bus.so_valid, bus.owner});
            end
            @(negedge clk);
        end
        rst = 1'b1;
    endtask

    task automatic test_single_port0();
        logic [3:0] d;
        d = 4'b1011;
        do_reset();
        bus.req0  = 1'b1;
        bus.data0 = d;
        tick();
        n_cmp++;
        if ({bus.gnt0, bus.gnt1} !== 2'b10) begin
            n_err++;
            $display("FAIL single_gnt: got %b expected 10", {bus.gnt0, bus.gnt1});
        end
        bus.req0 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if ({bus.so, bus.so_valid, bus.owner, bus.done} !== {d[i], 1'b1, 1'b0, 1'b0}) begin
                n_err++;
                $display("FAIL single_bit%0d: got so/vld/own/done %b expected %b", i,
                         {bus.so, bus.so_valid, bus.owner, bus.done}, {d[i], 3'b100});
            end
            tick();
        end
        n_cmp++;
        if ({bus.done, bus.so_valid} !== 2'b10) begin
            n_err++;
            $display("FAIL single_done: got done/vld %b expected 10", {bus.done, bus.so_valid});
        end
    endtask

    task automatic test_simultaneous();
        logic [7:0] s;
        s = {4'h3, 4'hA};
        do_reset();
        bus.req0  = 1'b1;
        bus.req1  = 1'b1;
        bus.data0 = 4'hA;
        bus.data1 = 4'h3;
        tick();
        n_cmp++;
        if ({bus.gnt0, bus.gnt1} !== 2'b10) begin
            n_err++;
            $display("FAIL simul_first_gnt: got %b expected 10", {bus.gnt0, bus.gnt1});
        end
        bus.req0 = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            n_cmp++;
            if ({bus.so_valid, bus.so} !== {1'b1, s[c-1]}) begin
                n_err++;
                $display("FAIL simul_bit_c%0d: got vld/so %b expected %b", c,
                         {bus.so_valid, bus.so}, {1'b1, s[c-1]});
            end
            if (c == 4 || c == 5) begin
                n_cmp++;
                if ({bus.gnt1, bus.done, bus.owner} !== ((c == 5) ? 3'b111 : 3'b000)) begin
                    n_err++;
                    $display("FAIL simul_handover_c%0d: got gnt1/done/own %b expected %b", c,
                             {bus.gnt1, bus.done, bus.owner}, (c == 5) ? 3'b111 : 3'b000);
                end
            end
            if (c == 5) bus.req1 = 1'b0;
            tick();
        end
        n_cmp++;
        if ({bus.done, bus.so_valid} !== 2'b10) begin
            n_err++;
            $display("FAIL simul_end: got done/vld %b expected 10", {bus.done, bus.so_valid});
        end
    endtask

    task automatic test_fairness();
        int order[$];
        int ndone;
        ndone = 0;
        do_reset();
        bus.req0  = 1'b1;
        bus.req1  = 1'b1;
        bus.data0 = 4'($urandom);
        bus.data1 = 4'($urandom);
        for (int c = 1; c <= 17; c++) begin
            tick();
            if (bus.gnt0) order.push_back(0);
            if (bus.gnt1) order.push_back(1);
            if (bus.done) ndone++;
            if (c == 13) begin
                bus.req0 = 1'b0;
                bus.req1 = 1'b0;
            end
        end
        n_cmp++;
        if (order.size() != 4) begin
            n_err++;
            $display("FAIL fair_count: got %0d grants expected 4", order.size());
        end
        for (int i = 0; i < order.size() && i < 4; i++) begin
            n_cmp++;
            if (order[i] != (i % 2)) begin
                n_err++;
                $display("FAIL fair_order%0d: got port %0d expected %0d", i, order[i], i % 2);
            end
        end
        n_cmp++;
        if (ndone != 4) begin
            n_err++;
            $display("FAIL fair_done: got %0d expected 4", ndone);
        end
    endtask

    task automatic test_pointer_independence();
        logic [3:0] d;
        d = 4'h8;
        do_reset();
        bus.req1  = 1'b1;
        bus.data1 = d;
        tick();
        n_cmp++;
        if ({bus.gnt0, bus.gnt1, bus.owner} !== 3'b011) begin
            n_err++;
            $display("FAIL ptr_gnt: got gnt0/gnt1/own %b expected 011", {bus.gnt0, bus.gnt1, bus.owner});
        end
        bus.req1 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if ({bus.so_valid, bus.so} !== {1'b1, d[i]}) begin
                n_err++;
                $display("FAIL ptr_bit%0d: got vld/so %b expected %b", i, {bus.so_valid, bus.so}, {1'b1, d[i]});
            end
            tick();
        end
    endtask

    task automatic test_reset_midword();
        do_reset();
        bus.req0  = 1'b1;
        bus.req1  = 1'b1;
        bus.data0 = 4'($urandom) | 4'b0100;
        bus.data1 = 4'($urandom);
        tick();
        bus.req0 = 1'b0;
        tick();
        tick();
        n_cmp++;
        if ({bus.so_valid, bus.so} !== 2'b11) begin
            n_err++;
            $display("FAIL midrst_pre: got vld/so %b expected 11", {bus.so_valid, bus.so});
        end
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        n_cmp++;
        if ({bus.gnt0, bus.gnt1, bus.done, bus.so, bus.so_valid, bus.owner} !== 6'b0) begin
            n_err++;
            $display("FAIL midrst_async: got %b expected 000000",
                     {bus.gnt0, bus.gnt1, bus.done, bus.so, bus.so_valid, bus.owner});
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            n_cmp++;
            if (bus.done !== 1'b0) begin
                n_err++;
                $display("FAIL midrst_no_done%0d: got %b expected 0", i, bus.done);
            end
        end
        @(negedge clk);
        rst = 1'b1;
        bus.req0  = 1'b1;
        bus.req1  = 1'b1;
        bus.data0 = 4'($urandom);
        tick();
        n_cmp++;
        if ({bus.gnt0, bus.gnt1, bus.owner} !== 3'b100) begin
            n_err++;
            $display("FAIL midrst_ptr: got gnt0/gnt1/own %b expected 100", {bus.gnt0, bus.gnt1, bus.owner});
        end
        clear_reqs();
        for (int i = 0; i < 5; i++) tick();
    endtask

    task automatic test_idle();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            tick();
            n_cmp++;
            if ({bus.gnt0, bus.gnt1, bus.done, bus.so, bus.so_valid} !== 5'b0) begin
                n_err++;
                $display("FAIL idle_c%0d: got %b expected 00000", i,
                         {bus.gnt0, bus.gnt1, bus.done, bus.so, bus.so_valid});
            end
        end
    endtask

    task automatic test_random();
        bit p0;
        bit p1;
        p0 = 0;
        p1 = 0;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            tick();
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL random_c%0d: got g0g1 dn so vld own %b expected %b", c, obs_vec(), exp_vec());
            end
            // A granted port drops req in its gnt cycle; idle ports may raise a fresh request.
            if (m_g0)      p0 = 0;
            else if (!p0 && $urandom_range(2) == 0) begin
                p0 = 1;
                bus.data0 = 4'($urandom);
            end
            if (m_g1)      p1 = 0;
            else if (!p1 && $urandom_range(2) == 0) begin
                p1 = 1;
                bus.data1 = 4'($urandom);
            end
            bus.req0 = p0;
            bus.req1 = p1;
        end
        clear_reqs();
    endtask

    initial begin
        clear_reqs();
        test_reset();
        test_single_port0();
        test_simultaneous();
        test_fairness();
        test_pointer_independence();
        test_reset_midword();
        test_idle();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
